// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: host-side driver for the ALU switch/button load protocol.
// Accepts one (A, B, opcode) command and loads A, B, then OP through sw plus
// one-hot strobes. Each load has a setup cycle, then HOLD_CYCLES strobe cycles.
// After SETTLE_CYCLES it samples led_in and presents the result on a
// valid/ready response port. Every output comes straight from a register.
// Optional build macro ALU_SEQ_OP_CACHE_EN: remembers the last loaded opcode
// and skips the OP load when a new command repeats it.
module alu_op_sequencer #(
  parameter int OPERAND_SIZE  = 8,
  parameter int OP_CODE_SIZE  = 6,
  parameter int HOLD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    CLK100MHZ,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPERAND_SIZE-1:0] cmd_a,
  input  logic [OPERAND_SIZE-1:0] cmd_b,
  input  logic [OP_CODE_SIZE-1:0] cmd_op,
  output logic [OPERAND_SIZE-1:0] sw,
  output logic                    btn_a,
  output logic                    btn_b,
  output logic                    btn_op,
  input  logic [OPERAND_SIZE-1:0] led_in,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [OPERAND_SIZE-1:0] rsp_data,
  output logic                    busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_LOAD_OP, S_SETTLE, S_RESP
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [OPERAND_SIZE-1:0] r_a;
  logic [OPERAND_SIZE-1:0] r_b;
  logic [OP_CODE_SIZE-1:0] r_op;

  logic [OPERAND_SIZE-1:0] r_sw;
  logic                    r_btn_a;
  logic                    r_btn_b;
  logic                    r_btn_op;
  logic                    r_rsp_valid;
  logic [OPERAND_SIZE-1:0] r_rsp_data;
  logic                    r_busy;
  logic                    r_cmd_ready;

  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_accept;
  logic                    w_capture;
  logic                    w_cache_hit;
  logic [OPERAND_SIZE-1:0] w_op_ext;
  logic [OPERAND_SIZE-1:0] w_sw_nxt;
  logic                    w_btn_a_nxt;
  logic                    w_btn_b_nxt;
  logic                    w_btn_op_nxt;

  // Opcode is presented zero-extended on the operand-wide sw bus.
  assign w_op_ext = OPERAND_SIZE'(r_op);

`ifdef ALU_SEQ_OP_CACHE_EN
  logic [OP_CODE_SIZE-1:0] r_last_op;
  logic                    r_last_vld;
  logic                    w_op_done;

  assign w_op_done   = (r_state == S_LOAD_OP) && (r_cnt == HOLD_LAST);
  assign w_cache_hit = r_last_vld && (r_last_op == r_op);

  // Remember the opcode the ALU last latched; the flag alone is reset.
  always_ff @(posedge CLK100MHZ) begin
    if (w_op_done) r_last_op <= r_op;
    if (reset) r_last_vld <= 1'b0;
    else if (w_op_done) r_last_vld <= 1'b1;
  end
`else
  assign w_cache_hit = 1'b0;
`endif

  // Next-state sequencing and the next value of every registered output.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_sw_nxt     = '0;
    w_btn_a_nxt  = 1'b0;
    w_btn_b_nxt  = 1'b0;
    w_btn_op_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_LOAD_A;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD_A: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_LOAD_B;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LOAD_B: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = w_cache_hit ? S_SETTLE : S_LOAD_OP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_LOAD_OP: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Count 0 of a load state is the setup cycle; the strobe follows it.
    case (w_state_nxt)
      S_LOAD_A: begin
        w_sw_nxt    = w_accept ? cmd_a : r_a;
        w_btn_a_nxt = (w_cnt_nxt != '0);
      end
      S_LOAD_B: begin
        w_sw_nxt    = r_b;
        w_btn_b_nxt = (w_cnt_nxt != '0);
      end
      S_LOAD_OP: begin
        w_sw_nxt     = w_op_ext;
        w_btn_op_nxt = (w_cnt_nxt != '0);
      end
      S_SETTLE, S_RESP: w_sw_nxt = w_op_ext;
      default:          w_sw_nxt = '0;
    endcase
  end

  // State, counter and output registers; reset forces the idle picture.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sw        <= '0;
      r_btn_a     <= 1'b0;
      r_btn_b     <= 1'b0;
      r_btn_op    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sw        <= w_sw_nxt;
      r_btn_a     <= w_btn_a_nxt;
      r_btn_b     <= w_btn_b_nxt;
      r_btn_op    <= w_btn_op_nxt;
      r_rsp_valid <= (w_state_nxt == S_RESP);
      if (w_capture) r_rsp_data <= led_in;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_cmd_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Command operands are captured once at acceptance and used from then on.
  always_ff @(posedge CLK100MHZ) begin
    if (w_accept) begin
      r_a  <= cmd_a;
      r_b  <= cmd_b;
      r_op <= cmd_op;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign sw        = r_sw;
  assign btn_a     = r_btn_a;
  assign btn_b     = r_btn_b;
  assign btn_op    = r_btn_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a default instance and a HOLD=3/SETTLE=4
// instance share one behavioural ALU that latches sw on the strobes.
// Expected results are queued at acceptance and popped at the response
// handshake; every cycle of each load sequence is compared with the
// expected sw/strobe waveform.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic       sel;
  logic       cmd_valid;
  logic [7:0] cmd_a, cmd_b;
  logic [5:0] cmd_op;
  logic       rsp_ready;
  logic [7:0] led_in;

  logic       cmd_valid1, cmd_valid2;
  logic       cmd_ready1, cmd_ready2;
  logic [7:0] sw1, sw2, rsp_data1, rsp_data2;
  logic       btn_a1, btn_b1, btn_op1, btn_a2, btn_b2, btn_op2;
  logic       rsp_valid1, rsp_valid2, busy1, busy2;

  logic       m_cmd_ready, m_btn_a, m_btn_b, m_btn_op, m_rsp_valid, m_busy;
  logic [7:0] m_sw, m_rsp_data;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];
  logic       c_vld[2];
  logic [5:0] c_last[2];

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;

  assign cmd_valid1 = cmd_valid & ~sel;
  assign cmd_valid2 = cmd_valid & sel;

  assign m_cmd_ready = sel ? cmd_ready2 : cmd_ready1;
  assign m_sw        = sel ? sw2 : sw1;
  assign m_btn_a     = sel ? btn_a2 : btn_a1;
  assign m_btn_b     = sel ? btn_b2 : btn_b1;
  assign m_btn_op    = sel ? btn_op2 : btn_op1;
  assign m_rsp_valid = sel ? rsp_valid2 : rsp_valid1;
  assign m_rsp_data  = sel ? rsp_data2 : rsp_data1;
  assign m_busy      = sel ? busy2 : busy1;

  alu_op_sequencer dut (
    .CLK100MHZ(clk), .reset(reset),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .sw(sw1), .btn_a(btn_a1), .btn_b(btn_b1), .btn_op(btn_op1),
    .led_in(led_in),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1),
    .busy(busy1)
  );

  alu_op_sequencer #(.HOLD_CYCLES(3), .SETTLE_CYCLES(4)) dut2 (
    .CLK100MHZ(clk), .reset(reset),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .sw(sw2), .btn_a(btn_a2), .btn_b(btn_b2), .btn_op(btn_op2),
    .led_in(led_in),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
    .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural ALU: operand registers load from sw on their button strobe.
  logic [7:0] ma, mb;
  logic [5:0] mop;
  always @(posedge clk) begin
    if (m_btn_a)  ma  <= m_sw;
    if (m_btn_b)  mb  <= m_sw;
    if (m_btn_op) mop <= m_sw[5:0];
  end
  assign led_in = alu_f(ma, mb, mop);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Issue one command on the selected instance, check its waveform and response.
  task automatic run_cmd(input logic s, input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op, input int hold, input logic pre,
                         input logic [7:0] na, input logic [7:0] nb, input logic [5:0] nop);
    int h_, s_, lat, n, idx, p, w, nload;
    logic hit;
    logic [7:0] ev_sw, exp_r, obs;
    logic [2:0] ev_btn;
    h_  = s ? 3 : 1;
    s_  = s ? 4 : 2;
    hit = 1'b0;
`ifdef ALU_SEQ_OP_CACHE_EN
    hit = c_vld[s] && (c_last[s] == op);
`endif
    nload = hit ? 2 : 3;
    lat   = nload * (1 + h_) + s_;
    exp_r = alu_f(a, b, op);
    sel = s; cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    n = 0;
    while (!m_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 50), 1);
    sb.push_back(exp_r);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 6'($urandom);
    for (int k = 1; k <= lat; k++) begin
      if (k > 1) @(negedge clk);
      idx = k - 1;
      p = idx / (1 + h_);
      w = idx % (1 + h_);
      if (p < nload) begin
        ev_sw  = (p == 0) ? a : (p == 1) ? b : {2'b00, op};
        ev_btn = (w >= 1) ? (3'b100 >> p) : 3'b000;
      end else begin
        ev_sw  = {2'b00, op};
        ev_btn = 3'b000;
      end
      chk("sw", m_sw, ev_sw);
      chk("strobe", {m_btn_a, m_btn_b, m_btn_op}, ev_btn);
      chk("ctl", {m_rsp_valid, m_busy, m_cmd_ready}, 3'b010);
    end
    @(negedge clk);
    chk("rsp_first", {m_rsp_valid, m_busy, m_cmd_ready, m_btn_a, m_btn_b, m_btn_op}, 6'b110000);
    for (int h = 0; h < hold; h++) begin
      if (pre) begin
        cmd_valid = 1'b1; cmd_a = na; cmd_b = nb; cmd_op = nop;
      end
      chk("rsp_hold", m_rsp_data, sb[0]);
      chk("hold_ctl", {m_rsp_valid, m_cmd_ready}, 2'b10);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    obs = m_rsp_data;
    chk("rsp_valid_hs", m_rsp_valid, 1);
    @(posedge clk);
    chk("rsp_data", obs, sb.pop_front());
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_ctl", {m_rsp_valid, m_busy, m_cmd_ready}, 3'b001);
    chk("post_sw", m_sw, 0);
    if (!hit) begin
      c_last[s] = op;
      c_vld[s]  = 1'b1;
    end
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] rop;
    int n;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR};
    c_vld[0] = 1'b0; c_vld[1] = 1'b0;
    c_last[0] = '0;  c_last[1] = '0;
    reset = 1'b1; sel = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0;
    repeat (3) @(negedge clk);
    chk("in_reset", {btn_a1, btn_b1, btn_op1, rsp_valid1, busy1, cmd_ready1}, 6'b000001);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ctl", {btn_a1, btn_b1, btn_op1, rsp_valid1, busy1, cmd_ready1}, 6'b000001);
    chk("idle_sw", sw1, 0);
    chk("idle_rsp_data", rsp_data1, 0);

    // AND with a stalled consumer and the next command waiting.
    run_cmd(1'b0, 8'h49, 8'h48, OP_AND, 5, 1'b1, 8'h0F, 8'hF0, OP_OR);
    run_cmd(1'b0, 8'h0F, 8'hF0, OP_OR, 0, 1'b0, 8'h00, 8'h00, 6'h00);

    // Reset during the B strobe abandons the command.
    sel = 1'b0; cmd_a = 8'h77; cmd_b = 8'h11; cmd_op = OP_SUB; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!btn_b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_pre_btn_b", btn_b1, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ctl", {btn_a1, btn_b1, btn_op1, rsp_valid1, busy1, cmd_ready1}, 6'b000001);
    chk("rst_mid_sw", sw1, 0);
    reset = 1'b0;
    c_vld[0] = 1'b0; c_vld[1] = 1'b0;

    // Same opcode as before reset: cache flag was cleared, full sequence.
    run_cmd(1'b0, 8'h12, 8'h34, OP_OR, 1, 1'b0, 8'h00, 8'h00, 6'h00);
    // Repeated opcode pair then a different one.
    run_cmd(1'b0, 8'h3C, 8'hF5, OP_AND, 0, 1'b0, 8'h00, 8'h00, 6'h00);
    run_cmd(1'b0, 8'hAA, 8'h0F, OP_AND, 0, 1'b0, 8'h00, 8'h00, 6'h00);
    run_cmd(1'b0, 8'h81, 8'h18, OP_OR, 2, 1'b0, 8'h00, 8'h00, 6'h00);

    for (int i = 0; i < 6; i++) begin
      rop = ops[$urandom_range(0, 5)];
      run_cmd(1'b0, 8'($urandom), 8'($urandom), rop, $urandom_range(0, 3), 1'b0,
              8'h00, 8'h00, 6'h00);
    end

    // Long hold / long settle instance.
    run_cmd(1'b1, 8'h21, 8'h0C, OP_SUB, 0, 1'b0, 8'h00, 8'h00, 6'h00);
    run_cmd(1'b1, 8'h5A, 8'hFF, OP_XOR, 2, 1'b0, 8'h00, 8'h00, 6'h00);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
